// File: rtl/bin2bcd.sv
// Iterative 16-bit binary to 5-digit packed BCD converter (double-dabble, one bit per cycle).
// Optional leading-zero blanking output out_en is built when BIN2BCD_LZB_EN is defined.
module bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [15:0] in_B,
  output logic [19:0] out_R,
  output logic        busy,
  output logic        done
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [4:0]  out_en
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [35:0] work_q, work_d;
  logic [35:0] corr_s, shifted_s;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Add 3 to every BCD nibble that is 5 or more, so the following shift carries correctly.
  function automatic logic [19:0] add3_nibbles(input logic [19:0] b);
    logic [19:0] r;
    r = 20'd0;
    for (int i = 0; i < 5; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

`ifdef BIN2BCD_LZB_EN
  // Digit i is shown when it or any more significant digit is nonzero; units always shown.
  function automatic logic [4:0] lzb_mask(input logic [19:0] b);
    logic [4:0] en;
    en[4] = |b[19:16];
    en[3] = en[4] | (|b[15:12]);
    en[2] = en[3] | (|b[11:8]);
    en[1] = en[2] | (|b[7:4]);
    en[0] = 1'b1;
    return en;
  endfunction

  logic [4:0] en_q, en_d;
  assign out_en = en_q;
`endif

  assign corr_s    = {add3_nibbles(work_q[35:16]), work_q[15:0]};
  assign shifted_s = corr_s << 1;

  assign out_R = out_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // State, work register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 36'd0;
      cnt_q   <= 5'd0;
      out_q   <= 20'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_LZB_EN
      en_q    <= 5'b00001;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIN2BCD_LZB_EN
      en_q    <= en_d;
`endif
    end
  end

  // Next-state logic; the 16th shift lands directly in DONE and publishes the result.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef BIN2BCD_LZB_EN
    en_d    = en_q;
`endif
    case (state_q)
      IDLE: begin
        if (init) begin
          work_d  = {20'd0, in_B};
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = shifted_s;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = DONE;
          out_d   = shifted_s[35:16];
`ifdef BIN2BCD_LZB_EN
          en_d    = lzb_mask(shifted_s[35:16]);
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule
